// File: rtl/tape_pkg.sv
// tape_pkg: shared widths, midscale baseline and activity FSM states for tape_cond.
package tape_pkg;
   localparam int               ADC_W    = 12;
   localparam logic [ADC_W-1:0] MIDSCALE = 12'd2048;
   localparam int               ACC_W    = 20;
   typedef enum logic [1:0] {IDLE, ARM, ACTIVE} state_t;
endpackage

// File: rtl/tape_glitch_filter.sv
// tape_glitch_filter: accepts a level change only after GLITCH consecutive disagreeing samples.
module tape_glitch_filter #(
   parameter int GLITCH = 4
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_valid,
   input  logic i_cand,
   output logic o_level,
   output logic o_edge
);
   logic [3:0] r_run;
   logic       r_level, r_edge;
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_run   <= '0;
         r_level <= 1'b0;
         r_edge  <= 1'b0;
      end else begin
         r_edge <= 1'b0;
         if (i_valid) begin
            if (i_cand == r_level) r_run <= '0;
            else if (r_run == 4'(GLITCH - 1)) begin
               r_run   <= '0;
               r_level <= ~r_level;
               r_edge  <= 1'b1;
            end else r_run <= r_run + 4'd1;
         end
      end
   end
   assign o_level = r_level;
   assign o_edge  = r_edge;
endmodule

// File: rtl/tape_cond.sv
// tape_cond: cassette input conditioner -- hysteresis comparator, glitch filter, activity FSM.
// Define TAPE_DCTRACK_EN to make the comparator baseline track the signal DC level.
module tape_cond
   import tape_pkg::*;
#(
   parameter logic [ADC_W-1:0] HYST      = 12'd64,
   parameter int               GLITCH    = 4,
   parameter int               TIMEOUT   = 16384,
   parameter int               ARM_EDGES = 8
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [ADC_W-1:0] i_adc_data,
   input  logic             i_adc_valid,
   output logic             o_tape_raw,
   output logic             o_tape,
   output logic             o_active,
   output logic             o_edge,
   output logic [ADC_W-1:0] o_level
);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam int EW = $clog2(ARM_EDGES + 1);
   logic [ADC_W-1:0] w_level, w_hi, w_lo;
   logic [ADC_W:0]   w_hi_sum;
   logic             w_cmp, r_cand, r_cvld, w_raw, w_edge;
   state_t           r_state, w_state;
   logic [IW-1:0]    r_idle, w_idle, w_idle_inc;
   logic [EW-1:0]    r_ecnt, w_ecnt;

`ifdef TAPE_DCTRACK_EN
   logic [ACC_W-1:0]        r_acc;
   logic signed [ADC_W:0]   w_diff;
   logic signed [ACC_W+1:0] w_acc_sum;
   // Accumulator holds the baseline with 8 fraction bits, so adding the raw difference is level += diff>>>8.
   always_comb begin
      w_diff    = $signed({1'b0, i_adc_data}) - $signed({1'b0, w_level});
      w_acc_sum = $signed({2'b00, r_acc}) + $signed({{(ACC_W-ADC_W+1){w_diff[ADC_W]}}, w_diff});
   end
   always_ff @(posedge i_clock) begin
      if (i_reset) r_acc <= {MIDSCALE, {(ACC_W-ADC_W){1'b0}}};
      else if (i_adc_valid)
         r_acc <= w_acc_sum[ACC_W+1] ? '0 : w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
   end
   assign w_level = r_acc[ACC_W-1 -: ADC_W];
`else
   assign w_level = MIDSCALE;
`endif

   always_comb begin
      w_hi_sum = {1'b0, w_level} + {1'b0, HYST};
      w_hi     = w_hi_sum[ADC_W] ? '1 : w_hi_sum[ADC_W-1:0];
      w_lo     = (w_level < HYST) ? '0 : w_level - HYST;
      w_cmp    = (i_adc_data > w_hi) ? 1'b1 : (i_adc_data < w_lo) ? 1'b0 : r_cand;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cand <= 1'b0;
         r_cvld <= 1'b0;
      end else begin
         r_cvld <= i_adc_valid;
         if (i_adc_valid) r_cand <= w_cmp;
      end
   end

   tape_glitch_filter #(.GLITCH(GLITCH)) u_filt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_valid (r_cvld),
      .i_cand  (r_cand),
      .o_level (w_raw),
      .o_edge  (w_edge)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_idle  <= '0;
         r_ecnt  <= '0;
      end else begin
         r_state <= w_state;
         r_idle  <= w_idle;
         r_ecnt  <= w_ecnt;
      end
   end

   // An edge always wins over a coincident timeout.
   always_comb begin
      w_state    = r_state;
      w_idle     = r_idle;
      w_ecnt     = r_ecnt;
      w_idle_inc = (r_idle == IW'(TIMEOUT)) ? r_idle : r_idle + IW'(1);
      if (w_edge) begin
         w_idle  = '0;
         w_ecnt  = (r_state == IDLE) ? EW'(1) : (r_state == ARM) ? r_ecnt + EW'(1) : r_ecnt;
         w_state = (r_state == ACTIVE || w_ecnt == EW'(ARM_EDGES)) ? ACTIVE : ARM;
      end else if (i_adc_valid) begin
         w_idle = w_idle_inc;
         if (w_idle_inc == IW'(TIMEOUT) && r_state != IDLE) begin
            w_state = IDLE;
            w_ecnt  = '0;
         end
      end
   end

   assign o_tape_raw = w_raw;
   assign o_edge     = w_edge;
   assign o_active   = (r_state == ACTIVE);
   assign o_tape     = w_raw & o_active;
   assign o_level    = w_level;
endmodule

// File: tb/tb_tape_cond.sv
// tb_tape_cond: vector table for comparator/filter/FSM plus sequences for wave, timeout, reset and DC level.
module tb_tape_cond;
   logic        clk = 1'b0, rst = 1'b1, valid = 1'b0;
   logic [11:0] data = 12'd0;
   logic        tape_raw, tape, active, edg;
   logic [11:0] level;

   tape_cond dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_adc_data  (data),
      .i_adc_valid (valid),
      .o_tape_raw  (tape_raw),
      .o_tape      (tape),
      .o_active    (active),
      .o_edge      (edg),
      .o_level     (level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] v;
      int          n;
      int          edges;
      logic        raw;
      logic        act;
   } vec_t;
   typedef struct {
      logic raw;
      logic act;
   } exp_t;

   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0, n_edges = 0, last_edge = 0;
   logic sb_on = 1'b0;
   exp_t q[$];
   vec_t tbl[15];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (edg) begin
         n_edges++;
         last_edge = cyc;
         if (sb_on) begin
            if (q.size() == 0) chk("sb_unexpected_edge", 1, 0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_raw", 32'(tape_raw), 32'(e.raw));
               chk("sb_active", 32'(active), 32'(e.act));
               chk("sb_tape", 32'(tape), 32'(e.raw & e.act));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic samp(input logic [11:0] v, input int n);
      repeat (n) begin
         @(negedge clk);
         data  = v;
         valid = 1'b1;
      end
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         @(negedge clk);
         valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_raw"}, 32'(tape_raw), 0);
      chk({nm, "_tape"}, 32'(tape), 0);
      chk({nm, "_active"}, 32'(active), 0);
      chk({nm, "_edge"}, 32'(edg), 0);
      chk({nm, "_level"}, 32'(level), 2048);
   endtask

   task automatic half(input int h, input logic act);
      exp_t e;
      e.raw = (h % 2 == 0);
      e.act = act;
      q.push_back(e);
      samp((h % 2 == 0) ? 12'd2600 : 12'd1500, 10);
   endtask

   initial begin
      int base, hit;
      tbl = '{
         '{12'd2048, 20, 0, 1'b0, 1'b0},
         '{12'd2600, 10, 1, 1'b1, 1'b0},
         '{12'd1500,  3, 1, 1'b1, 1'b0},
         '{12'd2600,  5, 1, 1'b1, 1'b0},
         '{12'd1500,  4, 2, 1'b0, 1'b0},
         '{12'd2600,  4, 3, 1'b1, 1'b0},
         '{12'd1500,  4, 4, 1'b0, 1'b0},
         '{12'd2112,  6, 4, 1'b0, 1'b0},
         '{12'd2113,  4, 5, 1'b1, 1'b0},
         '{12'd1984,  6, 5, 1'b1, 1'b0},
         '{12'd1983,  4, 6, 1'b0, 1'b0},
         '{12'd2600,  4, 7, 1'b1, 1'b0},
         '{12'd1500,  4, 8, 1'b0, 1'b1},
         '{12'd2048, 20, 8, 1'b0, 1'b1},
         '{12'd2600,  4, 9, 1'b1, 1'b1}
      };
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      rst = 1'b0;

      base = n_edges;
      for (int i = 0; i < 15; i++) begin
         samp(tbl[i].v, tbl[i].n);
         drain(4);
         chk($sformatf("vec%0d_edges", i), 32'(n_edges - base), 32'(tbl[i].edges));
         chk($sformatf("vec%0d_raw", i), 32'(tape_raw), 32'(tbl[i].raw));
         chk($sformatf("vec%0d_active", i), 32'(active), 32'(tbl[i].act));
         chk($sformatf("vec%0d_tape", i), 32'(tape), 32'(tbl[i].raw & tbl[i].act));
`ifndef TAPE_DCTRACK_EN
         chk($sformatf("vec%0d_level", i), 32'(level), 2048);
`endif
      end

      do_reset();
      sb_on = 1'b1;
      base  = n_edges;
      for (int h = 0; h < 20; h++) half(h, h >= 8);
      half(20, 1'b1);
      hit = 0;
      for (int i = 0; i < 17000 && hit == 0; i++) begin
         @(negedge clk);
         data  = 12'd2048;
         valid = 1'b1;
         if (cyc == last_edge + 16384) begin
            chk("to_active_before", 32'(active), 1);
            chk("to_tape_before", 32'(tape), 1);
         end
         if (cyc == last_edge + 16385) begin
            chk("to_active_after", 32'(active), 0);
            chk("to_tape_after", 32'(tape), 0);
            hit = 1;
         end
      end
      if (hit == 0) chk("to_reached", 0, 1);
      drain(4);
      chk("wave_edges", 32'(n_edges - base), 21);
      chk("wave_queue_empty", 32'(q.size()), 0);

      do_reset();
      for (int h = 0; h < 10; h++) half(h, h >= 8);
      chk("pre_rst_active", 32'(active), 1);
      samp(12'd2600, 2);
      @(negedge clk);
      rst   = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      rst  = 1'b0;
      base = n_edges;
      for (int h = 0; h < 7; h++) half(h, 1'b0);
      drain(4);
      chk("post_rst_edges", 32'(n_edges - base), 7);
      chk("post_rst_active", 32'(active), 0);
      chk("post_rst_queue_empty", 32'(q.size()), 0);
      sb_on = 1'b0;

      do_reset();
      samp(12'd3000, 4096);
      drain(2);
`ifdef TAPE_DCTRACK_EN
      chk("dc_level_near_3000", 32'((int'(level) >= 2992) && (int'(level) <= 3008)), 1);
`else
      chk("dc_level_fixed", 32'(level), 2048);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
